mem_frame_serializer: RTL and testbench

Successor to the LPC-capture memory-to-UART drain. It reads one fixed-size record from the capture RAM when the RAM is non-empty and frames it onto the byte-wide UART interface. Each frame is a programmable sync preamble, then the record bytes, then an optional XOR checksum byte. It sits between the capture RAM read port and the UART transmitter. Unlike the first generation it honours `uart_ready`, and record size, preamble, and checksum are all parametrised.

---
 rtl/mem_frame_serializer.sv | 158 +++++++++++++++
 tb/tb_mem_frame_serializer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_frame_serializer.sv
// Drains one fixed-size record from the capture RAM and frames it onto a byte-wide UART:
// optional sync preamble, the record bytes, then an optional XOR checksum byte.
module mem_frame_serializer #(
   parameter int          AW         = 16,
   parameter int          RB         = 3,
   parameter logic [7:0]  SYNC_BYTE  = 8'hFF,
   parameter int          SYNC_COUNT = 2,
   parameter bit          CSUM_EN    = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [7:0]       read_data,
   output logic [AW-1:0]    read_addr,
   input  logic [AW-RB-1:0] target_addr,
   input  logic             read_empty,
   output logic             read_done,
   input  logic             uart_ready,
   output logic [7:0]       uart_data,
   output logic             uart_latch,
   output logic             busy,
   output logic [15:0]      frame_count
);

   localparam int            TW        = AW - RB;
   localparam logic [RB-1:0] IDX_LAST  = '1;
   localparam logic [2:0]    SYNC_LAST = 3'(SYNC_COUNT - 1);

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      FETCH,
      SEND,
      CSUM,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   target_q, target_d;
   logic [RB-1:0]   idx_q, idx_d;
   logic [2:0]      sync_cnt_q, sync_cnt_d;
   logic [7:0]      csum_q, csum_d;
   logic [7:0]      rdata_q, rdata_d;
   logic [7:0]      data_q, data_d;
   logic [15:0]     frame_count_q, frame_count_d;
   logic            gap_q, gap_d;
   logic            held_q, held_d;
   logic            latch;
   logic [7:0]      txByte;
   logic [7:0]      recByte;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         target_q      <= '0;
         idx_q         <= '0;
         sync_cnt_q    <= '0;
         csum_q        <= '0;
         rdata_q       <= '0;
         data_q        <= '0;
         frame_count_q <= '0;
         gap_q         <= 1'b0;
         held_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         target_q      <= target_d;
         idx_q         <= idx_d;
         sync_cnt_q    <= sync_cnt_d;
         csum_q        <= csum_d;
         rdata_q       <= rdata_d;
         data_q        <= data_d;
         frame_count_q <= frame_count_d;
         gap_q         <= gap_d;
         held_q        <= held_d;
      end
   end

   // The RAM byte arrives in the first SEND cycle; it is captured there so a long stall cannot disturb it.
   always_comb begin
      state_d       = state_q;
      target_d      = target_q;
      idx_d         = idx_q;
      sync_cnt_d    = sync_cnt_q;
      csum_d        = csum_q;
      rdata_d       = rdata_q;
      frame_count_d = frame_count_q;
      held_d        = held_q;
      latch         = 1'b0;
      txByte        = 8'h00;
      recByte       = held_q ? rdata_q : read_data;

      case (state_q)
         IDLE: begin
            if (!read_empty) begin
               target_d   = target_addr;
               idx_d      = '0;
               sync_cnt_d = '0;
               csum_d     = '0;
               state_d    = (SYNC_COUNT > 0) ? SYNC : FETCH;
            end
         end
         SYNC: begin
            if (!gap_q && uart_ready) begin
               latch      = 1'b1;
               txByte     = SYNC_BYTE;
               sync_cnt_d = sync_cnt_q + 3'd1;
               if (sync_cnt_q == SYNC_LAST) state_d = FETCH;
            end
         end
         FETCH: begin
            held_d  = 1'b0;
            state_d = SEND;
         end
         SEND: begin
            if (!held_q) begin
               held_d  = 1'b1;
               rdata_d = read_data;
            end
            if (!gap_q && uart_ready) begin
               latch  = 1'b1;
               txByte = recByte;
               csum_d = csum_q ^ recByte;
               if (idx_q == IDX_LAST) begin
                  state_d = CSUM_EN ? CSUM : DONE;
               end else begin
                  idx_d   = idx_q + RB'(1);
                  state_d = FETCH;
               end
            end
         end
         CSUM: begin
            if (!gap_q && uart_ready) begin
               latch   = 1'b1;
               txByte  = csum_q;
               state_d = DONE;
            end
         end
         DONE: begin
            frame_count_d = frame_count_q + 16'd1;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A latch forces a one-cycle gap and the data register only moves when a byte is latched.
   always_comb begin
      gap_d  = latch;
      data_d = latch ? txByte : data_q;
   end

   assign uart_latch  = latch;
   assign uart_data   = latch ? txByte : data_q;
   assign read_addr   = {target_q, idx_q};
   assign read_done   = (state_q == DONE);
   assign busy        = (state_q != IDLE);
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_mem_frame_serializer.sv
// Randomised bench for mem_frame_serializer: two configurations share one RAM model, and every
// frame is compared against a queue built from the framing rules.
module tb_mem_frame_serializer;

   logic        clock;
   logic        reset;
   logic [7:0]  ram [0:65535];

   logic [7:0]  readDataA, uDataA;
   logic [15:0] readAddrA, fcA;
   logic [12:0] targetA;
   logic        emptyA, doneA, readyA, latchA, busyA;

   logic [7:0]  readDataB, uDataB;
   logic [15:0] readAddrB, fcB;
   logic [13:0] targetB;
   logic        emptyB, doneB, readyB, latchB, busyB;

   logic [7:0]  gotQ[$];
   int          addrQ[$];
   logic [7:0]  expQ[$];
   int          expAddr[$];
   int          doneCnt;
   int          violations;
   int          tests;
   int          fails;
   int          fcModelA;
   int          fcModelB;
   logic        prevLatchA, prevLatchB, prevDone;
   logic [7:0]  prevDataA, prevDataB;

   mem_frame_serializer dutA (
      .clock(clock), .reset(reset), .read_data(readDataA), .read_addr(readAddrA),
      .target_addr(targetA), .read_empty(emptyA), .read_done(doneA), .uart_ready(readyA),
      .uart_data(uDataA), .uart_latch(latchA), .busy(busyA), .frame_count(fcA)
   );

   mem_frame_serializer #(.RB(2), .SYNC_BYTE(8'hA5), .SYNC_COUNT(0), .CSUM_EN(1'b0)) dutB (
      .clock(clock), .reset(reset), .read_data(readDataB), .read_addr(readAddrB),
      .target_addr(targetB), .read_empty(emptyB), .read_done(doneB), .uart_ready(readyB),
      .uart_data(uDataB), .uart_latch(latchB), .busy(busyB), .frame_count(fcB)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      readDataA <= ram[readAddrA];
      readDataB <= ram[readAddrB];
   end

   // Collects latched bytes and flags any handshake breach: latch without ready, back-to-back
   // latches, data moving without a latch, or busy straight after a done pulse.
   always @(negedge clock) begin
      if (reset) begin
         prevLatchA = 1'b0;
         prevLatchB = 1'b0;
         prevDone   = 1'b0;
         prevDataA  = uDataA;
         prevDataB  = uDataB;
      end else begin
         if (latchA) begin
            if (!readyA || prevLatchA) violations++;
            gotQ.push_back(uDataA);
            addrQ.push_back(int'(readAddrA));
         end else if (uDataA !== prevDataA) violations++;
         if (latchB) begin
            if (!readyB || prevLatchB) violations++;
            gotQ.push_back(uDataB);
            addrQ.push_back(int'(readAddrB));
         end else if (uDataB !== prevDataB) violations++;
         if (prevDone && (busyA || busyB)) violations++;
         if (doneA || doneB) doneCnt++;
         prevDone   = doneA || doneB;
         prevLatchA = latchA;
         prevLatchB = latchB;
         prevDataA  = uDataA;
         prevDataB  = uDataB;
      end
   end

   task automatic modelFrame(input int tgt, input int rb, input int nSync,
                             input logic [7:0] sb, input bit csumEn);
      logic [7:0] x;
      logic [7:0] b;
      int         base;
      x    = 8'h00;
      base = tgt << rb;
      for (int i = 0; i < nSync; i++) begin
         expQ.push_back(sb);
         expAddr.push_back(-1);
      end
      for (int i = 0; i < (1 << rb); i++) begin
         b = ram[16'(base + i)];
         expQ.push_back(b);
         expAddr.push_back(base + i);
         x = x ^ b;
      end
      if (csumEn) begin
         expQ.push_back(x);
         expAddr.push_back(-1);
      end
   endtask

   task automatic applyStimulus(input bit selB, input int tgt, input bit randReady, output bit ok);
      int startDone;
      int stall;
      startDone = doneCnt;
      stall     = 0;
      ok        = 1'b0;
      gotQ.delete();
      addrQ.delete();
      if (selB) begin
         targetB = 14'(tgt);
         emptyB  = 1'b0;
      end else begin
         targetA = 13'(tgt);
         emptyA  = 1'b0;
      end
      @(posedge clock); #1;
      emptyA = 1'b1;
      emptyB = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if (randReady) begin
            if (stall > 0) begin
               readyA = 1'b0;
               stall--;
            end else begin
               readyA = 1'b1;
               if ($urandom_range(0, 1) == 1) stall = $urandom_range(1, 5);
            end
            readyB = readyA;
         end
         @(posedge clock); #1;
         if (doneCnt != startDone) begin
            ok = 1'b1;
            break;
         end
      end
      readyA = 1'b1;
      readyB = 1'b1;
   endtask

   task automatic test_reset;
      tests++; if (latchA !== 1'b0)     begin fails++; $display("[TB] FAIL reset.latch: got %b expected 0", latchA); end
      tests++; if (uDataA !== 8'h00)    begin fails++; $display("[TB] FAIL reset.data: got %02h expected 00", uDataA); end
      tests++; if (doneA !== 1'b0)      begin fails++; $display("[TB] FAIL reset.done: got %b expected 0", doneA); end
      tests++; if (readAddrA !== 16'h0) begin fails++; $display("[TB] FAIL reset.addr: got %04h expected 0000", readAddrA); end
      tests++; if (fcA !== 16'h0)       begin fails++; $display("[TB] FAIL reset.fc: got %0d expected 0", fcA); end
      tests++; if (busyA !== 1'b0)      begin fails++; $display("[TB] FAIL reset.busy: got %b expected 0", busyA); end
      tests++; if (busyB !== 1'b0 || fcB !== 16'h0) begin fails++; $display("[TB] FAIL reset.B: got busy %b fc %0d expected 0 0", busyB, fcB); end
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic test_basic_frame(input bit randReady, input string nm);
      bit ok;
      int startDone;
      for (int i = 0; i < 8; i++) ram[16'h0010 + i] = 8'(i + 1);
      expQ.delete();
      expAddr.delete();
      modelFrame(2, 3, 2, 8'hFF, 1'b1);
      startDone = doneCnt;
      applyStimulus(1'b0, 2, randReady, ok);
      fcModelA++;
      tests++; if (!ok) begin fails++; $display("[TB] FAIL %s.timeout: got no read_done expected one", nm); end
      tests++; if (gotQ.size() !== expQ.size()) begin fails++; $display("[TB] FAIL %s.len: got %0d expected %0d", nm, gotQ.size(), expQ.size()); end
      for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
         tests++; if (gotQ[i] !== expQ[i]) begin fails++; $display("[TB] FAIL %s.byte[%0d]: got %02h expected %02h", nm, i, gotQ[i], expQ[i]); end
         if (expAddr[i] >= 0) begin
            tests++; if (addrQ[i] !== expAddr[i]) begin fails++; $display("[TB] FAIL %s.addr[%0d]: got %04h expected %04h", nm, i, addrQ[i], expAddr[i]); end
         end
      end
      tests++; if (doneCnt - startDone !== 1) begin fails++; $display("[TB] FAIL %s.donecount: got %0d expected 1", nm, doneCnt - startDone); end
      tests++; if (fcA !== 16'(fcModelA)) begin fails++; $display("[TB] FAIL %s.fc: got %0d expected %0d", nm, fcA, fcModelA); end
      tests++; if (violations !== 0) begin fails++; $display("[TB] FAIL %s.handshake: got %0d violations expected 0", nm, violations); end
   endtask

   task automatic test_no_framing;
      bit ok;
      int tgt;
      tgt = $urandom_range(16, 16000);
      ram[16'(tgt * 4 + 0)] = 8'hAA;
      ram[16'(tgt * 4 + 1)] = 8'hBB;
      ram[16'(tgt * 4 + 2)] = 8'hCC;
      ram[16'(tgt * 4 + 3)] = 8'hDD;
      expQ.delete();
      expAddr.delete();
      modelFrame(tgt, 2, 0, 8'hA5, 1'b0);
      applyStimulus(1'b1, tgt, 1'b1, ok);
      fcModelB++;
      tests++; if (!ok) begin fails++; $display("[TB] FAIL noframe.timeout: got no read_done expected one"); end
      tests++; if (gotQ.size() !== 4) begin fails++; $display("[TB] FAIL noframe.len: got %0d expected 4", gotQ.size()); end
      for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
         tests++; if (gotQ[i] !== expQ[i]) begin fails++; $display("[TB] FAIL noframe.byte[%0d]: got %02h expected %02h", i, gotQ[i], expQ[i]); end
         tests++; if (addrQ[i] !== expAddr[i]) begin fails++; $display("[TB] FAIL noframe.addr[%0d]: got %04h expected %04h", i, addrQ[i], expAddr[i]); end
      end
      tests++; if (fcB !== 16'(fcModelB)) begin fails++; $display("[TB] FAIL noframe.fc: got %0d expected %0d", fcB, fcModelB); end
   endtask

   task automatic test_reset_mid_frame;
      bit ok;
      int startDone;
      for (int i = 0; i < 8; i++) ram[16'(5 * 8 + i)] = 8'($urandom);
      startDone = doneCnt;
      gotQ.delete();
      addrQ.delete();
      targetA = 13'd5;
      emptyA  = 1'b0;
      @(posedge clock); #1;
      emptyA = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (gotQ.size() >= 5) begin
            ok = 1'b1;
            break;
         end
         @(posedge clock); #1;
      end
      tests++; if (!ok) begin fails++; $display("[TB] FAIL midreset.start: got %0d bytes expected 5", gotQ.size()); end
      reset = 1'b1;
      #1;
      tests++; if ({latchA, uDataA, doneA, busyA} !== 11'h0 || readAddrA !== 16'h0 || fcA !== 16'h0) begin
         fails++; $display("[TB] FAIL midreset.outputs: got latch %b data %02h done %b busy %b addr %04h fc %0d expected all 0", latchA, uDataA, doneA, busyA, readAddrA, fcA);
      end
      @(posedge clock); #1;
      reset    = 1'b0;
      fcModelA = 0;
      fcModelB = 0;
      tests++; if (doneCnt !== startDone) begin fails++; $display("[TB] FAIL midreset.nodone: got %0d pulses expected 0", doneCnt - startDone); end
      @(posedge clock); #1;
      expQ.delete();
      expAddr.delete();
      modelFrame(5, 3, 2, 8'hFF, 1'b1);
      applyStimulus(1'b0, 5, 1'b0, ok);
      fcModelA++;
      tests++; if (gotQ.size() !== expQ.size()) begin fails++; $display("[TB] FAIL midreset.len: got %0d expected %0d", gotQ.size(), expQ.size()); end
      for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
         tests++; if (gotQ[i] !== expQ[i]) begin fails++; $display("[TB] FAIL midreset.byte[%0d]: got %02h expected %02h", i, gotQ[i], expQ[i]); end
      end
      tests++; if (fcA !== 16'(fcModelA)) begin fails++; $display("[TB] FAIL midreset.fc: got %0d expected %0d", fcA, fcModelA); end
   endtask

   task automatic test_back_to_back;
      int  tg[3];
      int  k;
      int  startDone;
      bit  scrambled;
      bit  ok;
      expQ.delete();
      expAddr.delete();
      for (int j = 0; j < 3; j++) begin
         tg[j] = $urandom_range(j * 2000 + 100, j * 2000 + 1900);
         for (int i = 0; i < 8; i++) ram[16'(tg[j] * 8 + i)] = 8'($urandom);
         modelFrame(tg[j], 3, 2, 8'hFF, 1'b1);
      end
      gotQ.delete();
      addrQ.delete();
      startDone = doneCnt;
      k         = 0;
      scrambled = 1'b0;
      ok        = 1'b0;
      targetA   = 13'(tg[0]);
      emptyA    = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clock); #1;
         if (doneCnt != startDone + k) begin
            k++;
            scrambled = 1'b0;
            if (k == 3) begin
               emptyA = 1'b1;
               ok     = 1'b1;
               break;
            end
            targetA = 13'(tg[k]);
         end else if (!scrambled && busyA) begin
            targetA   = 13'($urandom);
            scrambled = 1'b1;
         end
      end
      fcModelA += 3;
      tests++; if (!ok) begin fails++; $display("[TB] FAIL b2b.timeout: got %0d frames expected 3", k); end
      tests++; if (gotQ.size() !== expQ.size()) begin fails++; $display("[TB] FAIL b2b.len: got %0d expected %0d", gotQ.size(), expQ.size()); end
      for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
         tests++; if (gotQ[i] !== expQ[i]) begin fails++; $display("[TB] FAIL b2b.byte[%0d]: got %02h expected %02h", i, gotQ[i], expQ[i]); end
         if (expAddr[i] >= 0) begin
            tests++; if (addrQ[i] !== expAddr[i]) begin fails++; $display("[TB] FAIL b2b.addr[%0d]: got %04h expected %04h", i, addrQ[i], expAddr[i]); end
         end
      end
      tests++; if (fcA !== 16'(fcModelA)) begin fails++; $display("[TB] FAIL b2b.fc: got %0d expected %0d", fcA, fcModelA); end
      @(posedge clock); #1;
      tests++; if (busyA !== 1'b0) begin fails++; $display("[TB] FAIL b2b.stop: got busy %b expected 0", busyA); end
      tests++; if (violations !== 0) begin fails++; $display("[TB] FAIL b2b.handshake: got %0d violations expected 0", violations); end
   endtask

   task automatic checkOutput;
      bit ok;
      force dutB.frame_count_q = 16'hFFFF;
      #1;
      release dutB.frame_count_q;
      tests++; if (fcB !== 16'hFFFF) begin fails++; $display("[TB] FAIL wrap.preset: got %04h expected ffff", fcB); end
      applyStimulus(1'b1, 77, 1'b0, ok);
      tests++; if (!ok) begin fails++; $display("[TB] FAIL wrap.timeout: got no read_done expected one"); end
      tests++; if (fcB !== 16'h0000) begin fails++; $display("[TB] FAIL wrap.fc: got %04h expected 0000", fcB); end
   endtask

   initial begin
      tests      = 0;
      fails      = 0;
      doneCnt    = 0;
      violations = 0;
      fcModelA   = 0;
      fcModelB   = 0;
      for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
      reset   = 1'b1;
      emptyA  = 1'b1;
      emptyB  = 1'b1;
      readyA  = 1'b1;
      readyB  = 1'b1;
      targetA = '0;
      targetB = '0;
      repeat (3) @(posedge clock);
      #1;
      test_reset();
      test_basic_frame(1'b0, "basic");
      test_basic_frame(1'b1, "stall");
      test_no_framing();
      test_reset_mid_frame();
      test_back_to_back();
      checkOutput();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
